bsg_asic_iodelay_output_tuner: RTL

- Multi-channel run-time tap controller for output IODELAY2 primitives configured as IDELAY_TYPE="VARIABLE_FROM_ZERO", DELAY_SRC="ODATAIN", COUNTER_WRAPAROUND="STAY_AT_LIMIT".
- Replaces fixed per-bit ODELAY_VALUE with per-channel tap targets loaded over a valid/ready command port.
- Steps each delay one tap at a time via CE/INC and tracks the current tap of every channel.
- Sits between the ASIC-side configuration logic and the per-bit IODELAY2 instances. The primitives stay outside this block.

---
 rtl/bsg_asic_iodelay_output_tuner.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bsg_asic_iodelay_output_tuner.sv
// Run-time tap controller for a bank of output IODELAY2 primitives.
// Walks each channel's delay one tap at a time toward a commanded target.
module bsg_asic_iodelay_output_tuner #(
    parameter int channels_p  = 8,
    parameter int tap_width_p = 8,
    parameter int max_tap_p   = 255,
    parameter int settle_p    = 4,
    localparam int chan_w_lp  = (channels_p > 1) ? $clog2(channels_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              cmd_v_i,
    output logic                              cmd_ready_o,
    input  logic [chan_w_lp-1:0]              cmd_chan_i,
    input  logic [tap_width_p-1:0]            cmd_tap_i,
    output logic                              done_o,
    output logic                              err_o,
    output logic [channels_p-1:0]             dly_ce_o,
    output logic [channels_p-1:0]             dly_inc_o,
    output logic [channels_p-1:0]             dly_rst_o,
    input  logic [channels_p-1:0]             dly_busy_i,
    output logic [channels_p*tap_width_p-1:0] cur_tap_o
);

    typedef enum logic [2:0] {
        INIT,
        INIT_WAIT,
        IDLE,
        RESP,
        STEP,
        SETTLE,
        WAIT_BUSY
    } state_e;

    localparam logic [tap_width_p-1:0] max_tap_lp = tap_width_p'(max_tap_p);
    localparam logic [tap_width_p-1:0] one_lp     = tap_width_p'(1);
    localparam logic [3:0]             settle_lp  = 4'(settle_p);

    state_e                 state_q, state_d;
    logic [chan_w_lp-1:0]   chan_q, chan_d;
    logic [tap_width_p-1:0] tgt_q, tgt_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [tap_width_p-1:0] tap_q [channels_p];
    logic [tap_width_p-1:0] tap_d [channels_p];
    logic                   ready_q, ready_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [channels_p-1:0]  ce_q, ce_d;
    logic [channels_p-1:0]  inc_q, inc_d;
    logic [channels_p-1:0]  rst_q, rst_d;

    logic [chan_w_lp-1:0]   act_chan;
    logic [tap_width_p-1:0] act_tgt;
    logic [tap_width_p-1:0] cmd_tgt;
    logic [tap_width_p-1:0] cur_sel;
    logic                   busy_sel;
    logic                   act_ok;
    logic                   step_up;
    logic                   do_step;

    // In IDLE the incoming command is examined directly so the first
    // CE pulse can leave on the accepting edge.
    always_comb begin
        cmd_tgt  = (cmd_tap_i > max_tap_lp) ? max_tap_lp : cmd_tap_i;
        act_chan = (state_q == IDLE) ? cmd_chan_i : chan_q;
        act_tgt  = (state_q == IDLE) ? cmd_tgt : tgt_q;
        act_ok   = 1'b0;
        cur_sel  = '0;
        busy_sel = 1'b0;
        for (int i = 0; i < channels_p; i++) begin
            if (act_chan == chan_w_lp'(i)) begin
                act_ok   = 1'b1;
                cur_sel  = tap_q[i];
                busy_sel = dly_busy_i[i];
            end
        end
        step_up = (act_tgt > cur_sel);
    end

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        tap_d   = tap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ce_d    = '0;
        inc_d   = '0;
        rst_d   = '0;
        do_step = 1'b0;

        unique case (state_q)
            INIT: begin
                rst_d = '1;
                for (int i = 0; i < channels_p; i++) begin
                    tap_d[i] = '0;
                end
                state_d = INIT_WAIT;
            end
            INIT_WAIT: begin
                // BUSY is not trusted during the RST cycle itself.
                if (!(|rst_q) && !(|dly_busy_i)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (cmd_v_i && ready_q) begin
                    chan_d = cmd_chan_i;
                    tgt_d  = cmd_tgt;
                    if (!act_ok || (cmd_tgt == cur_sel)) begin
                        state_d = RESP;
                    end else begin
                        do_step = 1'b1;
                        state_d = STEP;
                    end
                end
            end
            RESP: begin
                err_d   = !act_ok;
                done_d  = act_ok;
                state_d = IDLE;
            end
            STEP: begin
                cnt_d   = settle_lp;
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!busy_sel) begin
                    if (cur_sel == tgt_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        do_step = 1'b1;
                        state_d = STEP;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        // Tracked tap moves on the same edge that raises CE.
        if (do_step) begin
            for (int i = 0; i < channels_p; i++) begin
                if (act_chan == chan_w_lp'(i)) begin
                    ce_d[i]  = 1'b1;
                    inc_d[i] = step_up;
                    tap_d[i] = step_up ? (tap_q[i] + one_lp)
                                       : (tap_q[i] - one_lp);
                end
            end
        end

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= INIT;
            chan_q  <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            tap_q   <= '{default: '0};
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ce_q    <= '0;
            inc_q   <= '0;
            rst_q   <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ce_q    <= ce_d;
            inc_q   <= inc_d;
            rst_q   <= rst_d;
        end
    end

    assign cmd_ready_o = ready_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign dly_ce_o    = ce_q;
    assign dly_inc_o   = inc_q;
    assign dly_rst_o   = rst_q;

    for (genvar g = 0; g < channels_p; g++) begin : g_tap
        assign cur_tap_o[g*tap_width_p +: tap_width_p] = tap_q[g];
    end

endmodule
